// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DBIT data bits, optional even/odd parity, one or two stop bits.
// Frame errors, parity errors and line breaks are reported alongside the received word.
module uart_rx_cfg #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  input  logic [1:0]      parity_mode,
  input  logic            stop2,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_BRKWAIT = 3'd5
  } state_t;

  function automatic logic parity_mismatch(input logic [DBIT-1:0] data, input logic pbit,
                                           input logic odd);
    return (^data) ^ pbit ^ odd;
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic            k_q, k_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [1:0]      pmode_q, pmode_d;
  logic            stop2_q, stop2_d;
  logic            pbit_q, pbit_d;
  logic            ferr_q, ferr_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            perr_q, perr_d;
  logic            frerr_q, frerr_d;
  logic            brk_q, brk_d;

  logic rx_s, tick_last, tick_half, par_en, stop_ferr, stop_more, frame_done;

  assign sync_d     = {sync_q[0], rx};
  assign rx_s       = sync_q[1];
  assign tick_last  = s_tick & (s_q == S_LAST);
  assign tick_half  = s_tick & (s_q == S_HALF);
  assign par_en     = (pmode_q == 2'b01) | (pmode_q == 2'b10);
  assign stop_ferr  = ferr_q | ~rx_s;
  assign stop_more  = stop2_q & ~k_q;
  assign frame_done = (state_q == ST_STOP) & tick_last & ~stop_more;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sync_q  <= 2'b11;
      s_q     <= {SW{1'b0}};
      n_q     <= {NW{1'b0}};
      k_q     <= 1'b0;
      b_q     <= {DBIT{1'b0}};
      pmode_q <= 2'b00;
      stop2_q <= 1'b0;
      pbit_q  <= 1'b0;
      ferr_q  <= 1'b0;
      dout_q  <= {DBIT{1'b0}};
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      frerr_q <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      s_q     <= s_d;
      n_q     <= n_d;
      k_q     <= k_d;
      b_q     <= b_d;
      pmode_q <= pmode_d;
      stop2_q <= stop2_d;
      pbit_q  <= pbit_d;
      ferr_q  <= ferr_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      frerr_q <= frerr_d;
      brk_q   <= brk_d;
    end
  end

  // Next-state logic; IDLE and BRKWAIT react every clk, the rest only on ticks
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (!rx_s) state_d = ST_START; else state_d = ST_IDLE;
      ST_START:   if (tick_half) state_d = rx_s ? ST_IDLE : ST_DATA; else state_d = ST_START;
      ST_DATA: begin
        if (tick_last && (n_q == N_LAST)) state_d = par_en ? ST_PARITY : ST_STOP;
        else state_d = ST_DATA;
      end
      ST_PARITY:  if (tick_last) state_d = ST_STOP; else state_d = ST_PARITY;
      ST_STOP: begin
        if (frame_done) state_d = stop_ferr ? ST_BRKWAIT : ST_IDLE;
        else state_d = ST_STOP;
      end
      ST_BRKWAIT: if (rx_s) state_d = ST_IDLE; else state_d = ST_BRKWAIT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Counters, shift register, per-frame config and output loading
  always_comb begin
    s_d = s_q;  n_d = n_q;  k_d = k_q;  b_d = b_q;
    pmode_d = pmode_q;  stop2_d = stop2_q;  pbit_d = pbit_q;  ferr_d = ferr_q;
    dout_d = dout_q;  perr_d = perr_q;  frerr_d = frerr_q;  brk_d = brk_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          s_d     = {SW{1'b0}};
          pmode_d = parity_mode;
          stop2_d = stop2;
          ferr_d  = 1'b0;
        end else begin
          s_d = s_q;
        end
      end
      ST_START: begin
        if (tick_half) begin
          s_d = {SW{1'b0}};
          n_d = {NW{1'b0}};
          k_d = 1'b0;
        end else if (s_tick) begin
          s_d = s_q + SW'(1);
        end else begin
          s_d = s_q;
        end
      end
      ST_DATA: begin
        if (tick_last) begin
          s_d = {SW{1'b0}};
          b_d = {rx_s, b_q[DBIT-1:1]};
          if (n_q != N_LAST) n_d = n_q + NW'(1); else n_d = n_q;
        end else if (s_tick) begin
          s_d = s_q + SW'(1);
        end else begin
          s_d = s_q;
        end
      end
      ST_PARITY: begin
        if (tick_last) begin
          pbit_d = rx_s;
          s_d    = {SW{1'b0}};
          k_d    = 1'b0;
        end else if (s_tick) begin
          s_d = s_q + SW'(1);
        end else begin
          s_d = s_q;
        end
      end
      ST_STOP: begin
        if (tick_last) begin
          ferr_d = stop_ferr;
          if (stop_more) begin
            k_d = 1'b1;
            s_d = {SW{1'b0}};
          end else begin
            dout_d  = b_q;
            perr_d  = par_en & parity_mismatch(b_q, pbit_q, pmode_q[1]);
            frerr_d = stop_ferr;
            brk_d   = stop_ferr & (b_q == {DBIT{1'b0}}) & (~par_en | ~pbit_q);
            done_d  = 1'b1;
          end
        end else if (s_tick) begin
          s_d = s_q + SW'(1);
        end else begin
          s_d = s_q;
        end
      end
      ST_BRKWAIT: s_d = s_q;
      default:    s_d = {SW{1'b0}};
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = frerr_q;
  assign break_det    = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8-bit and a 7-bit instance share clock, ticks, reset and config;
// expected frames are queued at send time and compared when rx_done_tick fires.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, s_tick, rx_a, rx_b, stop2;
  logic [1:0] pmode;
  logic [7:0] dout_a;
  logic [6:0] dout_b;
  logic       done_a, perr_a, ferr_a, brk_a;
  logic       done_b, perr_b, ferr_b, brk_b;

  uart_rx_cfg #(.DBIT(8), .OVERSAMPLE(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_a), .parity_mode(pmode),
    .stop2(stop2), .dout(dout_a), .rx_done_tick(done_a), .parity_err(perr_a),
    .frame_err(ferr_a), .break_det(brk_a));

  uart_rx_cfg #(.DBIT(7), .OVERSAMPLE(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_b), .parity_mode(pmode),
    .stop2(stop2), .dout(dout_b), .rx_done_tick(done_b), .parity_err(perr_b),
    .frame_err(ferr_b), .break_det(brk_b));

  typedef struct {
    logic [8:0] dout;
    logic       perr, ferr, brk;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] pm;
    logic       st2, pbit, s1, s2;
    logic [7:0] edout;
    logic       eperr, eferr, ebrk;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vecs[13];
  int   tests = 0, fails = 0;
  int   gticks = 0, start_tick = 0, lat_a = 0, lat_b = 0, cnt_a = 0, cnt_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    if (inst == 0) rx_a = v; else rx_b = v;
  endtask

  task automatic push_exp(input int inst, input logic [8:0] d, input logic pe, input logic fe,
                          input logic bk);
    exp_t e;
    e.dout = d; e.perr = pe; e.ferr = fe; e.brk = bk;
    if (inst == 0) q_a.push_back(e); else q_b.push_back(e);
  endtask

  task automatic check_frame(input int inst, input logic [8:0] d, input logic pe,
                             input logic fe, input logic bk);
    exp_t e;
    tests++;
    if ((inst == 0 && q_a.size() == 0) || (inst == 1 && q_b.size() == 0)) begin
      fails++;
      $display("FAIL unexpected_done inst%0d: got pulse dout=%h, want no pulse", inst, d);
    end else begin
      if (inst == 0) e = q_a.pop_front(); else e = q_b.pop_front();
      if ({d, pe, fe, bk} !== {e.dout, e.perr, e.ferr, e.brk}) begin
        fails++;
        $display("FAIL frame inst%0d: got dout=%h perr=%b ferr=%b brk=%b, want dout=%h perr=%b ferr=%b brk=%b",
                 inst, d, pe, fe, bk, e.dout, e.perr, e.ferr, e.brk);
      end
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    tests++;
    if ({dout_a, done_a, perr_a, ferr_a, brk_a, dout_b, done_b, perr_b, ferr_b, brk_b} !== 23'd0) begin
      fails++;
      $display("FAIL %s: got a=%h/%b%b%b%b b=%h/%b%b%b%b, want all zero", name, dout_a, done_a,
               perr_a, ferr_a, brk_a, dout_b, done_b, perr_b, ferr_b, brk_b);
    end
  endtask

  // Bounded wait for both scoreboards to empty
  task automatic wait_drain();
    for (int i = 0; i < 2000 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    check_val("drain_timeout_pending", q_a.size() + q_b.size(), 0);
  endtask

  task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                            input logic [1:0] pm, input logic st2, input logic pbit,
                            input logic s1, input logic s2, input int toggle_at);
    wait_ticks(1);
    @(negedge clk);
    pmode = pm; stop2 = st2; set_rx(inst, 1'b0); start_tick = gticks;
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      set_rx(inst, data[i]);
      if (i == toggle_at) stop2 = ~stop2;
      wait_ticks(16);
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      @(negedge clk); set_rx(inst, pbit); wait_ticks(16);
    end
    @(negedge clk); set_rx(inst, s1); wait_ticks(16);
    if (st2) begin
      @(negedge clk); set_rx(inst, s2); wait_ticks(16);
    end
    @(negedge clk); set_rx(inst, 1'b1);
    wait_ticks(32);
  endtask

  initial begin
    int c0, p, s, tcnt;
    logic [7:0] rd;
    vecs[0]  = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'hA7, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA7, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'hA7, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA7, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h3C, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{8'h81, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{8'h12, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{8'hC3, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'hC3, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{8'hFF, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0; s_tick = 1'b0; rx_a = 1'b1; rx_b = 1'b1; pmode = 2'b00; stop2 = 1'b0;

    fork
      begin : tick_gen
        tcnt = 0;
        forever begin
          @(negedge clk);
          s_tick = (tcnt == 0);
          tcnt = (tcnt + 1) % 4;
        end
      end
      forever begin
        @(posedge clk);
        if (s_tick) gticks = gticks + 1;
      end
      // Output monitor: pulse width, unexpected pulses, scoreboard compare
      forever begin
        @(negedge clk);
        if (prev_a) check_val("done_a_width", int'(done_a), 0);
        if (prev_b) check_val("done_b_width", int'(done_b), 0);
        if (done_a) begin
          cnt_a++; lat_a = gticks - start_tick;
          check_frame(0, {1'b0, dout_a}, perr_a, ferr_a, brk_a);
        end
        if (done_b) begin
          cnt_b++; lat_b = gticks - start_tick;
          check_frame(1, {2'b00, dout_b}, perr_b, ferr_b, brk_b);
        end
        prev_a = done_a; prev_b = done_b;
      end
      begin
        #1000000;
        $display("FAIL watchdog: got timeout, want bench completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (5) @(negedge clk);
    check_zero_outputs("reset_state");
    reset_n = 1'b1;
    wait_ticks(4);

    // Table-driven frames on the 8-bit instance, with latency from START entry
    for (int i = 0; i < 13; i++) begin
      push_exp(0, {1'b0, vecs[i].edout}, vecs[i].eperr, vecs[i].eferr, vecs[i].ebrk);
      send_frame(0, {1'b0, vecs[i].data}, 8, vecs[i].pm, vecs[i].st2, vecs[i].pbit,
                 vecs[i].s1, vecs[i].s2, -1);
      wait_drain();
      p = (vecs[i].pm == 2'b01 || vecs[i].pm == 2'b10) ? 1 : 0;
      s = vecs[i].st2 ? 2 : 1;
      check_val($sformatf("latency_vec%0d", i), lat_a, 8 + 16 * (8 + p + s));
    end

    // Glitch: short low pulse must be rejected
    c0 = cnt_a;
    wait_ticks(1);
    @(negedge clk); pmode = 2'b00; stop2 = 1'b0; rx_a = 1'b0;
    wait_ticks(4);
    @(negedge clk); rx_a = 1'b1;
    wait_ticks(40);
    check_val("glitch_no_done", cnt_a, c0);
    push_exp(0, 9'h03C, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    wait_drain();

    // Break: 12 bit-times low yields exactly one frame
    c0 = cnt_a;
    push_exp(0, 9'h000, 1'b0, 1'b1, 1'b1);
    wait_ticks(1);
    @(negedge clk); rx_a = 1'b0; start_tick = gticks;
    wait_ticks(192);
    check_val("break_one_done", cnt_a, c0 + 1);
    check_val("break_latency", lat_a, 152);
    @(negedge clk); rx_a = 1'b1;
    wait_ticks(32);
    check_val("break_no_more", cnt_a, c0 + 1);
    push_exp(0, 9'h081, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h081, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    wait_drain();

    // 7O2 with low second stop; stop2 toggled mid-frame must not matter
    push_exp(1, 9'h05A, 1'b0, 1'b1, 1'b0);
    send_frame(1, 9'h05A, 7, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 3);
    wait_drain();
    check_val("b_7o2_latency", lat_b, 168);
    push_exp(1, 9'h07F, 1'b0, 1'b0, 1'b0);
    send_frame(1, 9'h07F, 7, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 2);
    wait_drain();
    check_val("b_7e1_latency", lat_b, 152);

    // Reset during data bit 3 discards the frame
    c0 = cnt_a;
    rd = 8'hA5;
    wait_ticks(1);
    @(negedge clk); pmode = 2'b00; stop2 = 1'b0; rx_a = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rx_a = rd[i];
      wait_ticks(i == 3 ? 8 : 16);
    end
    @(negedge clk); reset_n = 1'b0; rx_a = 1'b1;
    @(negedge clk);
    check_zero_outputs("midframe_reset");
    wait_ticks(4);
    @(negedge clk); reset_n = 1'b1;
    wait_ticks(48);
    check_val("reset_no_done", cnt_a, c0);
    push_exp(0, 9'h0F0, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h0F0, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    wait_drain();
    check_val("f0_latency", lat_a, 152);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver for the serial I/O subsystem. It sits between the `baud_gen` oversampling tick and the byte-consumer logic. It generalises the fixed 8N1 receiver with:

- configurable data width and oversampling;
- runtime parity and stop-bit selection;
- an input synchroniser and false-start rejection;
- parity, framing and break reporting.

## Interface
Parameters:
- `DBIT`, default 8: data bits per frame, legal 5..9.
- `OVERSAMPLE`, default 16: `s_tick` pulses per bit period, even, legal 4..32.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_tick`  in  1  oversampling strobe, one `clk` wide.
- `rx`  in  1  asynchronous serial line, idle high.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- `stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `dout`  out  `DBIT`  last received data word.
- `rx_done_tick`  out  1  one-`clk` pulse, frame complete.
- `parity_err`  out  1  parity mismatch on last frame.
- `frame_err`  out  1  a stop bit sampled low on last frame.
- `break_det`  out  1  last frame was a line break.

## Operation
**Synchroniser**
- `rx` passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised value `rx_s`.

**Per-frame configuration**
- `parity_mode` and `stop2` are latched on the IDLE→START transition.
- Changes mid-frame have no effect on the frame in progress.

**Counters**
- Tick counter `s`: width `$clog2(OVERSAMPLE)`.
- Bit counter `n`: width `$clog2(DBIT)`.
- Stop-bit counter `k`: 1 bit.
- Shift register `b`: `DBIT` bits.

**State machine**
- **IDLE**: when `rx_s`==0, clear `s`, latch config, go to START.
- **START**: on each tick, if `s`==`OVERSAMPLE/2-1`:
  - `rx_s`==1: glitch; go to IDLE with no output change.
  - `rx_s`==0: clear `s` and `n`, go to DATA.
  - Otherwise `s`++.
- **DATA**: on each tick, if `s`==`OVERSAMPLE-1`:
  - clear `s`; shift `b` = {`rx_s`, `b[DBIT-1:1]`} (LSB first);
  - if `n`==`DBIT-1`, go to PARITY when parity is enabled, else STOP; otherwise `n`++.
  - Otherwise `s`++.
- **PARITY**: on the tick where `s`==`OVERSAMPLE-1`:
  - capture the parity bit, clear `s`, clear `k`, go to STOP.
  - Even mode: an error exists when XOR(data, parity bit) != 0. Odd mode: an error exists when it != 1.
- **STOP**: on the tick where `s`==`OVERSAMPLE-1`:
  - sample `rx_s`; any low sample sets the internal frame-error flag.
  - If `stop2` is set and `k`==0: set `k`, clear `s`, stay in STOP.
  - Otherwise complete the frame.
- **Frame completion** (same edge):
  - load `dout` from `b`;
  - load `parity_err` (forced to 0 when parity is disabled) and `frame_err`;
  - `break_det` = `frame_err` AND all data bits 0 AND (parity disabled OR parity bit 0);
  - pulse `rx_done_tick`.
  - Next state: BRKWAIT if `frame_err`, else IDLE.
- **BRKWAIT**: stay until `rx_s`==1, then go to IDLE. A held-low line produces no further frames.

**Output behaviour**
- Outputs change only at frame completion and hold until the next completion.
- Glitch rejections and reset-free aborts produce no output change.

## Timing
**Reset**
- Async assert; all outputs 0, `b` and counters 0, state IDLE, synchroniser flops 1.
- Mid-frame reset discards the partial frame.

**Latency**
- `rx` falling edge to START entry: 2–3 `clk`.
- START entry to completion: `OVERSAMPLE/2` + `OVERSAMPLE`·(`DBIT` + P + S) ticks, where P ∈ {0,1} and S ∈ {1,2}.

**Completion cycle**
- `rx_done_tick` is registered: high for exactly the one `clk` after the edge that consumes the final stop tick.
- `dout` and the error flags are valid in that same cycle.

**Tick rules**
- Tick-gated decisions occur only on `clk` edges where `s_tick`=1. Without ticks the state holds.
- IDLE and BRKWAIT evaluate every `clk`, independent of `s_tick`.
- The `s` counter never exceeds `OVERSAMPLE-1`; there is no wrap outside the resets listed above.

## Test plan
1. **8N1 baseline**: `OVERSAMPLE`=16, 8N1, frame 0x55 → `dout`=0x55; `rx_done_tick` high for one `clk`; all error flags 0; total 152 ticks from START entry.
2. **Even-parity error**: 8E1 frame 0xA7 with parity bit 0 (correct bit is 1) → `dout`=0xA7, `parity_err`=1, `frame_err`=0. Resend with parity bit 1 → `parity_err`=0.
3. **Glitch rejection**: `rx` low for 4 ticks, then high → no `rx_done_tick`, FSM back in IDLE. A following 8N1 frame 0x3C → `dout`=0x3C.
4. **Break**: `rx` held low for 12 bit-times, 8N1 → exactly one `rx_done_tick` with `dout`=0x00, `frame_err`=1, `break_det`=1. No further pulse until `rx` returns high; the next frame 0x81 is received cleanly.
5. **Two stop bits, `DBIT`=7**: 7O2 frame 0x5A with the second stop bit low → `frame_err`=1, `break_det`=0, `parity_err`=0, `dout`=0x5A. Also toggle `stop2` mid-frame → no effect on that frame.
6. **Reset mid-frame**: pull `reset_n` low during DATA bit 3 → all outputs 0, no `rx_done_tick`. The next 8N1 frame 0xF0 gives `dout`=0xF0, errors 0.
